csr_trap_ctrl: RTL and testbench

Trap and return sequencer for the machine-mode CSR register file. Accepts a synchronous exception, an external interrupt or an `mret` from the pipeline. Drives the CSR file's single write port and asynchronous read port over several cycles to update mepc/mcause/mtval/mstatus (or restore them), then issues a one-cycle PC redirect. The pipeline stalls on `busy` for the whole sequence.

---
 rtl/csr_trap_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Machine-mode trap / mret sequencer sitting in front of the CSR register
//   file. An accepted exception or interrupt walks the CSR write port through
//   mepc, mcause, mtval and mstatus, then reads mtvec and issues a one-cycle
//   PC redirect. An accepted mret rewrites mstatus while reading mepc, then
//   redirects to the saved PC. The pipeline stalls on busy throughout.
//
// Optional feature macro: TRAP_VECTORED_EN
//   defined   : vectored mtvec mode (mtvec[1:0]==2'b01) offsets interrupt
//               targets by cause*4; exceptions still go to the base.
//   undefined : mtvec[1:0] ignored, every trap goes to the base.
//
// Parameters
//   RESET_VEC      redirect_pc value after reset / before the first redirect
// Ports
//   clk, rst       clock; synchronous active-high reset
//   exc_req        exception request (level, held until req_ack)
//   exc_cause      mcause for the exception
//   exc_val        mtval for the exception
//   mret_req       mret request (level, held until req_ack)
//   irq_in         external interrupt line
//   trap_pc        PC saved into mepc
//   mstatus_in     current mstatus
//   mie_in         current mie
//   csr_rdata      CSR read data (combinational from csr_raddr)
//   csr_raddr      CSR read address (0 when unused)
//   csr_waddr      CSR write address (0 when no write)
//   csr_wdata      CSR write data (0 when no write)
//   csr_w          CSR write enable
//   csr_wsc_mode   2'b01 while writing, else 2'b00
//   req_ack        one-cycle accept pulse for exc/mret
//   busy           sequence in progress
//   redirect_valid one-cycle fetch redirect
//   redirect_pc    redirect target (holds its last value otherwise)
module csr_trap_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_val,
  input  logic        mret_req,
  input  logic        irq_in,
  input  logic [31:0] trap_pc,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_raddr,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_w,
  output logic [1:0]  csr_wsc_mode,
  output logic        req_ack,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

  typedef enum logic [3:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STATUS,
    T_VEC,
    M_STATUS,
    M_REDIR
  } state_t;

  state_t      state, state_nx;

  logic [31:0] pc_q, cause_q, val_q, mepc_q, last_pc_q;

  logic        irq_take;
  logic        load_trap;
  logic [31:0] load_cause, load_val;
  logic [31:0] vec_base, vec_pc, target_pc;
  logic [31:0] trap_mstatus, mret_mstatus;

  // Only mie[11] (MEIE) matters here.
  logic        unused_mie;
  assign unused_mie = ^{mie_in[31:12], mie_in[10:0]};

  assign irq_take = irq_in & mstatus_in[3] & mie_in[11];

  // MPIE <- MIE, MIE <- 0, MPP <- 2'b11
  assign trap_mstatus = (mstatus_in & ~32'h0000_1888)
                      | {24'b0, mstatus_in[3], 7'b0}
                      | 32'h0000_1800;
  // MIE <- MPIE, MPIE <- 1
  assign mret_mstatus = (mstatus_in & ~32'h0000_0088)
                      | {28'b0, mstatus_in[7], 3'b0}
                      | 32'h0000_0080;

  assign vec_base = {csr_rdata[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign vec_pc = (csr_rdata[1:0] == 2'b01 && cause_q[31])
                ? vec_base + {25'b0, cause_q[4:0], 2'b00}
                : vec_base;
`else
  assign vec_pc = vec_base;
`endif

  always_comb begin
    state_nx       = state;
    csr_raddr      = '0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    csr_w          = 1'b0;
    req_ack        = 1'b0;
    redirect_valid = 1'b0;
    target_pc      = last_pc_q;
    load_trap      = 1'b0;
    load_cause     = '0;
    load_val       = '0;

    case (state)
      IDLE: begin
        if (exc_req) begin
          state_nx   = T_EPC;
          req_ack    = ~rst;
          load_trap  = 1'b1;
          load_cause = exc_cause;
          load_val   = exc_val;
        end else if (mret_req) begin
          state_nx   = M_STATUS;
          req_ack    = ~rst;
        end else if (irq_take) begin
          state_nx   = T_EPC;
          load_trap  = 1'b1;
          load_cause = IRQ_CAUSE;
          load_val   = '0;
        end
      end
      T_EPC: begin
        csr_w     = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = pc_q;
        state_nx  = T_CAUSE;
      end
      T_CAUSE: begin
        csr_w     = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = cause_q;
        state_nx  = T_TVAL;
      end
      T_TVAL: begin
        csr_w     = 1'b1;
        csr_waddr = A_MTVAL;
        csr_wdata = val_q;
        state_nx  = T_STATUS;
      end
      T_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = trap_mstatus;
        state_nx  = T_VEC;
      end
      T_VEC: begin
        csr_raddr      = A_MTVEC;
        redirect_valid = 1'b1;
        target_pc      = vec_pc;
        state_nx       = IDLE;
      end
      // mepc is read over the async port in the same cycle mstatus is written
      M_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mret_mstatus;
        csr_raddr = A_MEPC;
        state_nx  = M_REDIR;
      end
      M_REDIR: begin
        redirect_valid = 1'b1;
        target_pc      = mepc_q;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign csr_wsc_mode = csr_w ? 2'b01 : 2'b00;
  assign busy         = (state != IDLE);
  assign redirect_pc  = target_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      val_q     <= '0;
      mepc_q    <= '0;
      last_pc_q <= RESET_VEC;
    end else begin
      state <= state_nx;
      if (load_trap) begin
        pc_q    <= trap_pc;
        cause_q <= load_cause;
        val_q   <= load_val;
      end
      if (state == M_STATUS)
        mepc_q <= csr_rdata;
      if (redirect_valid)
        last_pc_q <= target_pc;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl
//   Scoreboard bench for csr_trap_ctrl. Stimulus pushes expected events
//   (accept pulse, CSR write, redirect) tagged with the cycle they must
//   appear in; a negedge monitor pops and compares every event the DUT
//   presents. A small CSR model supplies mtvec/mepc on the read port.
module tb_csr_trap_ctrl;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, mret_req, irq_in;
  logic [31:0] exc_cause, exc_val, trap_pc, mstatus_in, mie_in, csr_rdata;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  logic        csr_w, req_ack, busy, redirect_valid;
  logic [1:0]  csr_wsc_mode;

  csr_trap_ctrl #(.RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_val(exc_val),
    .mret_req(mret_req), .irq_in(irq_in), .trap_pc(trap_pc),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .csr_rdata(csr_rdata),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode), .req_ack(req_ack),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: mtvec set by stimulus, mepc written by the DUT or preloaded
  logic [31:0] mtvec_cfg;
  logic [31:0] mepc_m = '0;
  logic        mepc_load = 1'b0;
  logic [31:0] mepc_load_val = '0;
  always @(posedge clk) begin
    if (csr_w && csr_waddr == 12'h341) mepc_m <= csr_wdata;
    else if (mepc_load)                mepc_m <= mepc_load_val;
  end
  always_comb begin
    csr_rdata = '0;
    if (csr_raddr == 12'h305) csr_rdata = mtvec_cfg;
    if (csr_raddr == 12'h341) csr_rdata = mepc_m;
  end

  typedef struct {
    int          kind;   // 0 ack, 1 write, 2 redirect
    int unsigned cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  logic mon_en = 1'b0;

  function automatic void push(int kind, int unsigned c, logic [11:0] a, logic [31:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(int kind, logic [11:0] a, logic [31:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d addr=%h data=%h, expected none",
               kind, cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.addr != a || e.data != d) begin
        fails++;
        $display("FAIL event: got kind=%0d cyc=%0d addr=%h data=%h, expected kind=%0d cyc=%0d addr=%h data=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_ack)        check_ev(0, 12'h0, 32'h0);
      if (csr_w)          check_ev(1, csr_waddr, csr_wdata);
      if (redirect_valid) check_ev(2, 12'h0, redirect_pc);
      if (csr_w && csr_wsc_mode != 2'b01) begin
        fails++;
        $display("FAIL wsc_mode: got %b, expected 01", csr_wsc_mode);
      end
      if (!csr_w && (csr_wsc_mode != 2'b00 || csr_waddr != 12'h0 || csr_wdata != 32'h0)) begin
        fails++;
        $display("FAIL idle_write_port: mode=%b waddr=%h wdata=%h, expected all zero",
                 csr_wsc_mode, csr_waddr, csr_wdata);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Count busy cycles starting from the current (first busy) cycle.
  task automatic busy_len(string name, int exp);
    int cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step(1);
    end
    chk(name, cnt, exp);
  endtask

  task automatic push_trap(int unsigned c, logic [31:0] pc, logic [31:0] cause,
                           logic [31:0] val, logic [31:0] mst, logic [31:0] tgt);
    push(1, c + 1, 12'h341, pc);
    push(1, c + 2, 12'h342, cause);
    push(1, c + 3, 12'h343, val);
    push(1, c + 4, 12'h300, mst);
    push(2, c + 5, 12'h0, tgt);
  endtask

  logic [31:0] vec_exp;
  int unsigned c;

  initial begin
`ifdef TRAP_VECTORED_EN
    vec_exp = 32'h0000_022C;
`else
    vec_exp = 32'h0000_0200;
`endif
    rst = 1'b1; exc_req = 0; mret_req = 0; irq_in = 0;
    exc_cause = '0; exc_val = '0; trap_pc = '0;
    mstatus_in = '0; mie_in = '0; mtvec_cfg = 32'h200;
    step(3);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_csr_w", {31'b0, csr_w}, 0);
    chk("rst_redir_valid", {31'b0, redirect_valid}, 0);
    chk("rst_raddr", {20'b0, csr_raddr}, 0);
    chk("rst_redir_pc", redirect_pc, RV);
    rst = 1'b0;
    mon_en = 1'b1;
    step(2);
    chk("idle_busy", {31'b0, busy}, 0);

    // Exception trap
    c = cyc;
    exc_req = 1; exc_cause = 32'd2; exc_val = 32'hDEAD_BEEF;
    trap_pc = 32'h100; mstatus_in = 32'h88;
    push(0, c, 12'h0, 32'h0);
    push_trap(c, 32'h100, 32'd2, 32'hDEAD_BEEF, 32'h1880, 32'h200);
    step(1);
    exc_req = 0;
    busy_len("trap_busy_len", 5);
    step(2);
    chk("redir_pc_hold", redirect_pc, 32'h200);

    // mret
    mstatus_in = 32'h1880; mepc_load_val = 32'h104; mepc_load = 1;
    step(1);
    mepc_load = 0;
    c = cyc;
    mret_req = 1;
    push(0, c, 12'h0, 32'h0);
    push(1, c + 1, 12'h300, 32'h1888);
    push(2, c + 2, 12'h0, 32'h104);
    step(1);
    mret_req = 0;
    busy_len("mret_busy_len", 2);

    // Interrupt masked by MIE, then enabled
    mie_in = 32'h800; mstatus_in = 32'h0; irq_in = 1; mtvec_cfg = 32'h201;
    trap_pc = 32'h300;
    step(4);
    chk("irq_masked_busy", {31'b0, busy}, 0);
    c = cyc;
    mstatus_in = 32'h8;
    push_trap(c, 32'h300, 32'h8000_000B, 32'h0, 32'h1880, vec_exp);
    step(1);
    irq_in = 0;
    busy_len("irq_busy_len", 5);
    step(2);

    // exc + mret + irq together: trap first, held mret right after
    mstatus_in = 32'h88; mtvec_cfg = 32'h200; trap_pc = 32'h400;
    exc_cause = 32'd7; exc_val = 32'h55;
    c = cyc;
    exc_req = 1; mret_req = 1; irq_in = 1;
    push(0, c, 12'h0, 32'h0);
    push_trap(c, 32'h400, 32'd7, 32'h55, 32'h1880, 32'h200);
    push(0, c + 6, 12'h0, 32'h0);
    push(1, c + 7, 12'h300, 32'h88);
    push(2, c + 8, 12'h0, 32'h400);
    step(1);
    exc_req = 0;
    step(6);
    mret_req = 0; irq_in = 0;
    step(3);

    // Reset during T_TVAL
    c = cyc;
    exc_req = 1; exc_cause = 32'd3; exc_val = 32'h77; trap_pc = 32'h500;
    push(0, c, 12'h0, 32'h0);
    push(1, c + 1, 12'h341, 32'h500);
    push(1, c + 2, 12'h342, 32'd3);
    push(1, c + 3, 12'h343, 32'h77);
    step(1);
    exc_req = 0;
    step(2);
    rst = 1;
    step(1);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_csr_w", {31'b0, csr_w}, 0);
    chk("midrst_redir_valid", {31'b0, redirect_valid}, 0);
    chk("midrst_ack", {31'b0, req_ack}, 0);
    chk("midrst_raddr", {20'b0, csr_raddr}, 0);
    chk("midrst_redir_pc", redirect_pc, RV);
    rst = 0;
    step(6);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
